rw_req_arbiter: RTL



---
 rtl/rw_req_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/rw_req_arbiter.sv
// Round-robin arbiter sharing one read/write transaction engine among NUM_REQ requesters.
// Retries failed transactions with a fixed backoff gap, then returns a one-hot completion pulse.
module rw_req_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned RETRY_GAP = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*16-1:0]  req_page,
    input  logic [NUM_REQ*64-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     resp_done,
    output logic                   resp_success,
    output logic [63:0]            resp_rdata,
    output logic                   busy,
    output logic                   start_read,
    output logic                   start_write,
    output logic [15:0]            RWmemPage,
    output logic [63:0]            RW_data_write,
    input  logic                   protocol_free,
    input  logic                   rwFSM_done,
    input  logic                   read_success,
    input  logic                   write_success,
    input  logic [63:0]            RW_data_read
);
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_BACKOFF = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0]          r_state;
    logic [IW-1:0]       r_idx;
    logic                r_op;
    logic [15:0]         r_page;
    logic [63:0]         r_wdata;
    logic [RW-1:0]       r_retry_cnt;
    logic [GW-1:0]       r_gap_cnt;
    logic [IW-1:0]       r_rr_ptr;
    logic [NUM_REQ-1:0]  r_resp_done;
    logic                r_resp_success;
    logic [63:0]         r_resp_rdata;
    logic                r_busy;
    logic                r_start_read;
    logic                r_start_write;

    logic [2:0]          w_next;
    logic                w_any;
    logic [IW-1:0]       w_win;
    logic                w_ok;
    logic [IW-1:0]       w_idx_nxt;
    logic                w_op_nxt;
    logic [15:0]         w_page_nxt;
    logic [63:0]         w_wdata_nxt;
    logic [RW-1:0]       w_retry_nxt;
    logic [GW-1:0]       w_gap_nxt;
    logic [IW-1:0]       w_rr_nxt;
    logic [63:0]         w_rdata_nxt;
    logic                w_success_nxt;

    // First requester at or above rr_ptr, wrapping; scanning downward lets the nearest one win.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (req_valid[IW'((int'(r_rr_ptr) + k) % int'(NUM_REQ))]) begin
                w_any = 1'b1;
                w_win = IW'((int'(r_rr_ptr) + k) % int'(NUM_REQ));
            end
        end
    end

    assign w_ok = r_op ? write_success : read_success;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_idx_nxt     = r_idx;
        w_op_nxt      = r_op;
        w_page_nxt    = r_page;
        w_wdata_nxt   = r_wdata;
        w_retry_nxt   = r_retry_cnt;
        w_gap_nxt     = r_gap_cnt;
        w_rr_nxt      = r_rr_ptr;
        w_rdata_nxt   = r_resp_rdata;
        w_success_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next      = S_ISSUE;
                    w_idx_nxt   = w_win;
                    w_op_nxt    = req_write[w_win];
                    w_page_nxt  = req_page[32'(w_win) * 16 +: 16];
                    w_wdata_nxt = req_wdata[32'(w_win) * 64 +: 64];
                    w_retry_nxt = '0;
                end
            end
            S_ISSUE: begin
                if (protocol_free) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rwFSM_done) begin
                    if (w_ok || (r_retry_cnt == RW'(MAX_RETRY))) begin
                        w_next        = S_RESP;
                        w_success_nxt = w_ok;
                        if (w_ok && !r_op) begin
                            w_rdata_nxt = RW_data_read;
                        end
                    end else begin
                        w_next      = S_BACKOFF;
                        w_retry_nxt = r_retry_cnt + RW'(1);
                        w_gap_nxt   = GW'(RETRY_GAP - 1);
                    end
                end
            end
            S_BACKOFF: begin
                if (r_gap_cnt == '0) begin
                    w_next = S_ISSUE;
                end else begin
                    w_gap_nxt = r_gap_cnt - GW'(1);
                end
            end
            S_RESP: begin
                w_next   = S_IDLE;
                w_rr_nxt = IW'((int'(r_idx) + 1) % int'(NUM_REQ));
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx          <= '0;
            r_op           <= 1'b0;
            r_page         <= '0;
            r_wdata        <= '0;
            r_retry_cnt    <= '0;
            r_gap_cnt      <= '0;
            r_rr_ptr       <= '0;
            r_resp_done    <= '0;
            r_resp_success <= 1'b0;
            r_resp_rdata   <= '0;
            r_busy         <= 1'b0;
            r_start_read   <= 1'b0;
            r_start_write  <= 1'b0;
        end else begin
            r_idx          <= w_idx_nxt;
            r_op           <= w_op_nxt;
            r_page         <= w_page_nxt;
            r_wdata        <= w_wdata_nxt;
            r_retry_cnt    <= w_retry_nxt;
            r_gap_cnt      <= w_gap_nxt;
            r_rr_ptr       <= w_rr_nxt;
            r_resp_rdata   <= w_rdata_nxt;
            r_resp_success <= w_success_nxt;
            r_busy         <= (w_next != S_IDLE);
            r_start_read   <= (w_next == S_ISSUE) && !w_op_nxt;
            r_start_write  <= (w_next == S_ISSUE) && w_op_nxt;
            r_resp_done    <= (w_next == S_RESP) ? (NUM_REQ'(1) << w_idx_nxt) : '0;
        end
    end

    assign resp_done     = r_resp_done;
    assign resp_success  = r_resp_success;
    assign resp_rdata    = r_resp_rdata;
    assign busy          = r_busy;
    assign start_read    = r_start_read;
    assign start_write   = r_start_write;
    assign RWmemPage     = r_page;
    assign RW_data_write = r_wdata;

endmodule
